// File: rtl/serial_pkg.sv
// serial_pkg
//   Shared types and line levels for the bit-serial transmitter.
//   tx_state_t enumerates the frame FSM states; the line-level constants name
//   the idle, start and stop levels of the asynchronous frame so the FSM reads
//   in protocol terms rather than raw 1'b0/1'b1.
package serial_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    localparam logic LINE_IDLE = 1'b1;
    localparam logic START_LVL = 1'b0;
    localparam logic STOP_LVL  = 1'b1;

endpackage

// File: rtl/bit_timer.sv
// bit_timer
//   Baud counter for the serial transmitter. Counts 0..CLKS_PER_BIT-1 while
//   run is high and wraps on every bit boundary; held at zero while run is low
//   so each frame starts on a fresh bit period.
//
// Ports:
//   clk    in   system clock, rising edge
//   reset  in   asynchronous, active-high reset
//   run    in   high while a frame is in progress
//   tick   out  high on the last clk cycle of each serial bit
module bit_timer #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    output logic tick
);

    localparam int            CW   = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (!run || cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    assign tick = run && (cnt == LAST);

endmodule

// File: rtl/serial_tx.sv
// serial_tx
//   Bit-serial transmitter. Accepts a parallel word over a valid/ready
//   handshake and sends it as an asynchronous frame: start bit, DATA_W data
//   bits LSB-first, optional parity bit, stop bit. Each bit is held for
//   CLKS_PER_BIT clk cycles.
//
//   Optional feature: define SERIAL_TX_PARITY_EN to insert a parity bit after
//   the data bits (even parity by default, odd when PARITY_ODD=1).
//
// Ports:
//   clk       in   system clock, rising edge
//   reset     in   asynchronous, active-high reset (aborts any frame)
//   tx_data   in   word to send, sampled only on handshake
//   tx_valid  in   producer has a word
//   tx_ready  out  block can accept a word (high only in IDLE)
//   tx_out    out  serial line, idles high
//   tx_busy   out  frame in progress
//   tx_done   out  one-cycle pulse in the first IDLE cycle after a frame
module serial_tx #(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 4
`ifdef SERIAL_TX_PARITY_EN
    ,
    parameter bit PARITY_ODD   = 1'b0
`endif
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              tx_out,
    output logic              tx_busy,
    output logic              tx_done
);

    import serial_pkg::*;

    localparam int            BW       = $clog2(DATA_W + 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);

    if (CLKS_PER_BIT < 2) begin : g_chk_clks
        $error("serial_tx: CLKS_PER_BIT must be >= 2");
    end
    if (DATA_W < 1 || DATA_W > 16) begin : g_chk_width
        $error("serial_tx: DATA_W must be in 1..16");
    end

    tx_state_t         state;
    logic [DATA_W-1:0] shreg;
    logic [DATA_W-1:0] shreg_nxt;
    logic [BW-1:0]     bitcnt;
    logic              tick;
`ifdef SERIAL_TX_PARITY_EN
    logic              par_bit;
`endif

    // tx_out is registered, so on a shift the line must already carry the
    // bit that will sit in shreg[0] after the shift.
    assign shreg_nxt = shreg >> 1;

    // The timer runs exactly while a frame is in progress; tx_busy is the
    // registered "not IDLE" flag, so it doubles as the run enable.
    bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_timer (
        .clk  (clk),
        .reset(reset),
        .run  (tx_busy),
        .tick (tick)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            tx_out   <= LINE_IDLE;
            tx_ready <= 1'b1;
            tx_busy  <= 1'b0;
            tx_done  <= 1'b0;
            bitcnt   <= '0;
            shreg    <= '0;
`ifdef SERIAL_TX_PARITY_EN
            par_bit  <= 1'b0;
`endif
        end else begin
            tx_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (tx_valid && tx_ready) begin
                        shreg    <= tx_data;
`ifdef SERIAL_TX_PARITY_EN
                        par_bit  <= (^tx_data) ^ PARITY_ODD;
`endif
                        bitcnt   <= '0;
                        state    <= START;
                        tx_out   <= START_LVL;
                        tx_ready <= 1'b0;
                        tx_busy  <= 1'b1;
                    end
                end
                START: begin
                    if (tick) begin
                        state  <= DATA;
                        tx_out <= shreg[0];
                    end
                end
                DATA: begin
                    if (tick) begin
                        if (bitcnt == LAST_BIT) begin
                            bitcnt <= '0;
`ifdef SERIAL_TX_PARITY_EN
                            state  <= PARITY;
                            tx_out <= par_bit;
`else
                            state  <= STOP;
                            tx_out <= STOP_LVL;
`endif
                        end else begin
                            bitcnt <= bitcnt + BW'(1);
                            shreg  <= shreg_nxt;
                            tx_out <= shreg_nxt[0];
                        end
                    end
                end
`ifdef SERIAL_TX_PARITY_EN
                PARITY: begin
                    if (tick) begin
                        state  <= STOP;
                        tx_out <= STOP_LVL;
                    end
                end
`endif
                STOP: begin
                    if (tick) begin
                        state    <= IDLE;
                        tx_out   <= LINE_IDLE;
                        tx_ready <= 1'b1;
                        tx_busy  <= 1'b0;
                        tx_done  <= 1'b1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    tx_out   <= LINE_IDLE;
                    tx_ready <= 1'b1;
                    tx_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_tx.sv
// tb_serial_tx
//   Scoreboard bench for serial_tx. Two instances: the default 8-bit / 4-clk
//   configuration and a minimal 1-bit / 2-clk one. Frames are hand-written as
//   {stop, [parity,] data, start} so bit 0 is the first bit on the line.
module tb_serial_tx;

    localparam int C  = 4;
    localparam int SC = 2;

`ifdef SERIAL_TX_PARITY_EN
    localparam int NB  = 11;
    localparam int SNB = 4;
    localparam logic [15:0] F_A5 = {5'b0, 11'b1_0_10100101_0};
    localparam logic [15:0] F_3C = {5'b0, 11'b1_0_00111100_0};
    localparam logic [15:0] F_FF = {5'b0, 11'b1_0_11111111_0};
    localparam logic [15:0] F_0F = {5'b0, 11'b1_0_00001111_0};
    localparam logic [15:0] F_01 = {5'b0, 11'b1_1_00000001_0};
    localparam logic [15:0] F_07 = {5'b0, 11'b1_1_00000111_0};
    localparam logic [15:0] F_S1 = {12'b0, 4'b1_1_1_0};
`else
    localparam int NB  = 10;
    localparam int SNB = 3;
    localparam logic [15:0] F_A5 = {6'b0, 10'b1_10100101_0};
    localparam logic [15:0] F_3C = {6'b0, 10'b1_00111100_0};
    localparam logic [15:0] F_FF = {6'b0, 10'b1_11111111_0};
    localparam logic [15:0] F_0F = {6'b0, 10'b1_00001111_0};
    localparam logic [15:0] F_01 = {6'b0, 10'b1_00000001_0};
    localparam logic [15:0] F_07 = {6'b0, 10'b1_00000111_0};
    localparam logic [15:0] F_S1 = {13'b0, 3'b1_1_0};
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] tx_data;
    logic       tx_valid, tx_ready, tx_out, tx_busy, tx_done;
    logic [0:0] s_data;
    logic       s_valid, s_ready, s_out, s_busy, s_done;

    bit exp_bits[$];
    int exp_done[$];
    bit s_bits[$];
    int s_done_q[$];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    bit mon_en  = 1'b0;
    int a0, a1;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    serial_tx #(.DATA_W(8), .CLKS_PER_BIT(C)) u_dut (
        .clk(clk), .reset(reset), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .tx_out(tx_out), .tx_busy(tx_busy), .tx_done(tx_done)
    );

    serial_tx #(.DATA_W(1), .CLKS_PER_BIT(SC)) u_small (
        .clk(clk), .reset(reset), .tx_data(s_data), .tx_valid(s_valid),
        .tx_ready(s_ready), .tx_out(s_out), .tx_busy(s_busy), .tx_done(s_done)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_evt(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: event not expected by scoreboard (cycle %0d)", name, cyc);
    endtask

    // Monitor for the 8-bit instance: every busy cycle consumes one expected
    // line level; every tx_done consumes one expected completion cycle.
    always @(negedge clk) begin
        if (mon_en) begin
            if (tx_busy) begin
                chk("busy_ready", tx_ready, 0);
                chk("busy_done", tx_done, 0);
                if (exp_bits.size() == 0) fail_evt("unexpected_frame_bit");
                else chk("tx_out", tx_out, exp_bits.pop_front());
            end else begin
                chk("idle_line", tx_out, 1);
            end
            if (tx_done) begin
                if (exp_done.size() == 0) fail_evt("unexpected_tx_done");
                else chk("tx_done_cycle", cyc, exp_done.pop_front());
            end
        end
    end

    // Monitor for the 1-bit instance.
    always @(negedge clk) begin
        if (mon_en) begin
            if (s_busy) begin
                chk("s_busy_done", s_done, 0);
                if (s_bits.size() == 0) fail_evt("s_unexpected_frame_bit");
                else chk("s_tx_out", s_out, s_bits.pop_front());
            end else begin
                chk("s_idle_line", s_out, 1);
            end
            if (s_done) begin
                if (s_done_q.size() == 0) fail_evt("s_unexpected_tx_done");
                else chk("s_tx_done_cycle", cyc, s_done_q.pop_front());
            end
        end
    end

    // Called at a negedge. Presents the word, waits for tx_ready, and at the
    // cycle of acceptance (t) pushes the expected frame and completion cycle.
    task automatic issue(input int inst, input logic [7:0] d, input logic [15:0] frame,
                         input int nb, input bit keep, output int acc);
        int n = 0;
        int c;
        c = (inst == 0) ? C : SC;
        if (inst == 0) begin tx_valid = 1'b1; tx_data = d; end
        else begin s_valid = 1'b1; s_data = d[0:0]; end
        while ((((inst == 0) ? tx_ready : s_ready) !== 1'b1) && n < 500) begin
            @(negedge clk);
            n++;
        end
        acc = cyc;
        if (n >= 500) begin
            fail_evt("accept_timeout");
        end else begin
            for (int i = 0; i < nb; i++)
                for (int k = 0; k < c; k++)
                    if (inst == 0) exp_bits.push_back(frame[i]);
                    else s_bits.push_back(frame[i]);
            if (inst == 0) exp_done.push_back(cyc + nb * c + 1);
            else s_done_q.push_back(cyc + nb * c + 1);
        end
        @(negedge clk);
        if (inst == 0) begin tx_data = ~d; if (!keep) tx_valid = 1'b0; end
        else begin s_data = ~d[0:0]; if (!keep) s_valid = 1'b0; end
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_bits.size() + exp_done.size() + s_bits.size() + s_done_q.size()) != 0
               && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 1000) fail_evt("drain_timeout");
        repeat (3) @(negedge clk);
    endtask

    initial begin
        reset    = 1'b1;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        s_valid  = 1'b0;
        s_data   = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_tx_out", tx_out, 1);
        chk("rst_tx_ready", tx_ready, 1);
        chk("rst_tx_busy", tx_busy, 0);
        chk("rst_tx_done", tx_done, 0);
        chk("rst_s_out", s_out, 1);
        #2 reset = 1'b0;
        mon_en = 1'b1;

        repeat (20) begin
            @(negedge clk);
            chk("idle_tx_out", tx_out, 1);
            chk("idle_tx_ready", tx_ready, 1);
            chk("idle_tx_busy", tx_busy, 0);
            chk("idle_tx_done", tx_done, 0);
        end

        issue(0, 8'hA5, F_A5, NB, 1'b0, a0);
        drain();

        issue(0, 8'h3C, F_3C, NB, 1'b1, a0);
        issue(0, 8'hFF, F_FF, NB, 1'b0, a1);
        chk("b2b_spacing", a1 - a0, NB * C + 1);
        drain();

        issue(0, 8'h0F, F_0F, NB, 1'b0, a0);
        while (cyc < a0 + 15) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("abort_tx_out", tx_out, 1);
        chk("abort_tx_busy", tx_busy, 0);
        chk("abort_tx_ready", tx_ready, 1);
        exp_bits.delete();
        exp_done.delete();
        @(negedge clk);
        @(negedge clk);
        #2 reset = 1'b0;
        @(negedge clk);
        issue(0, 8'h01, F_01, NB, 1'b0, a0);
        drain();

        issue(0, 8'h07, F_07, NB, 1'b0, a0);
        drain();

        issue(1, 8'h01, F_S1, SNB, 1'b0, a0);
        drain();

        chk("leftover_expectations",
            exp_bits.size() + exp_done.size() + s_bits.size() + s_done_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
